// File: rtl/sdr_tune_ctrl_if.sv
// UART-side byte handshake for the SDR tuning controller.
// master = UART wrapper (drives received bytes and tx busy), slave = controller.
// tx_dv is a single-cycle start strobe; tx_byte stays valid after it.
interface sdr_tune_ctrl_if;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       tx_active;
   logic       tx_dv;
   logic [7:0] tx_byte;

   modport master (output rx_dv, rx_byte, tx_active, input tx_dv, tx_byte);
   modport slave  (input rx_dv, rx_byte, tx_active, output tx_dv, tx_byte);
endinterface

// File: rtl/sdr_tune_ctrl.sv
// UART command decoder driving per-channel NCO phase increments and CIC gain.
// Latency: outputs and update register one cycle after the byte that completes a command.
// Backpressure: ACK waits on tx_active; bytes arriving in ACK are dropped (sticky rx_overrun).
// Optional macro SDR_TUNE_CTRL_ACK_EN enables the ACK state and acknowledge bytes.
module sdr_tune_ctrl #(
   parameter int                 PHASE_W        = 64,
   parameter int                 NUM_CH         = 2,
   parameter int                 GAIN_W         = 8,
   parameter int                 GAIN_MAX       = 3,
   parameter logic [PHASE_W-1:0] PRESET_A       = 64'h04CF41F212D77318,
   parameter logic [PHASE_W-1:0] PRESET_B       = 64'h01AA60F8B8911654,
   parameter logic [PHASE_W-1:0] STEP_COARSE    = 64'h00071B375868D170,
   parameter logic [PHASE_W-1:0] STEP_MID       = 64'h0000CA22980BA57E,
   parameter logic [PHASE_W-1:0] STEP_FINE      = 64'h00001436A8CDF6F3,
   parameter logic [PHASE_W-1:0] MAX_INC        = 64'h2000000000000000,
   parameter int                 TIMEOUT_CYCLES = 8000000,
   localparam int                CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   sdr_tune_ctrl_if.slave            bus,
   output logic [NUM_CH*PHASE_W-1:0] phase_inc,
   output logic [GAIN_W-1:0]         cic_gain,
   output logic [CH_W-1:0]           active_ch,
   output logic                      update,
   output logic                      rx_overrun
);
   localparam int DIGITS = PHASE_W / 4;
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] ACK_OK    = "K";
   localparam logic [7:0] ACK_CLAMP = "!";
   localparam logic [7:0] ACK_BAD   = "?";

   typedef enum logic [1:0] {
      ST_IDLE, ST_HEX, ST_CHSEL
`ifdef SDR_TUNE_CTRL_ACK_EN
      , ST_ACK
`endif
   } state_t;

`ifdef SDR_TUNE_CTRL_ACK_EN
   localparam state_t ST_AFTER = ST_ACK;
`else
   localparam state_t ST_AFTER = ST_IDLE;
`endif

   state_t               state_q, state_d;
   logic [PHASE_W-1:0]   phase_q [NUM_CH];
   logic [PHASE_W-1:0]   phase_d [NUM_CH];
   logic [GAIN_W-1:0]    gain_q, gain_d;
   logic [CH_W-1:0]      ach_q, ach_d;
   logic [PHASE_W-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [7:0]           ack_q, ack_d;
   logic                 upd_q, upd_d;
   logic                 ovr_q, ovr_d;

   logic                 go_hex, go_chsel, done, tmo_exp, in_cmd;
   logic                 step_up, step_dn;
   logic [PHASE_W-1:0]   step, cur, hex_word;
   logic [PHASE_W:0]     sum;
   logic [4:0]           hv;

   // Returns {valid, nibble} for an ASCII hex digit.
   function automatic logic [4:0] hex_val(input logic [7:0] b);
      logic [4:0] r;
      r = 5'd0;
      if (b >= "0" && b <= "9") r = {1'b1, b[3:0]};
      else if ((b >= "a" && b <= "f") || (b >= "A" && b <= "F")) r = {1'b1, b[3:0] + 4'd9};
      return r;
   endfunction

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         for (int k = 0; k < NUM_CH; k++) phase_q[k] <= '0;
         gain_q <= '0; ach_q <= '0; sr_q <= '0; cnt_q <= '0; tmo_q <= '0;
         ack_q  <= '0; upd_q <= 1'b0; ovr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int k = 0; k < NUM_CH; k++) phase_q[k] <= phase_d[k];
         gain_q <= gain_d; ach_q <= ach_d; sr_q <= sr_d; cnt_q <= cnt_d; tmo_q <= tmo_d;
         ack_q  <= ack_d;  upd_q <= upd_d; ovr_q <= ovr_d;
      end
   end

   // Next-state logic; a byte arriving on the expiry cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (go_hex)        state_d = ST_HEX;
            else if (go_chsel) state_d = ST_CHSEL;
            else if (done)     state_d = ST_AFTER;
         end
         ST_HEX, ST_CHSEL: if (done) state_d = ST_AFTER;
`ifdef SDR_TUNE_CTRL_ACK_EN
         ST_ACK: if (!bus.tx_active) state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Command decode and datapath next values; only the active channel is ever written.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) phase_d[k] = phase_q[k];
      gain_d  = gain_q;  ach_d = ach_q;  sr_d = sr_q;  cnt_d = cnt_q;
      ack_d   = ack_q;   upd_d = 1'b0;   ovr_d = ovr_q;
      go_hex  = 1'b0;    go_chsel = 1'b0; done = 1'b0;
      step_up = 1'b0;    step_dn = 1'b0;  step = '0;
      sum     = '0;
      cur      = phase_q[ach_q];
      hv       = hex_val(bus.rx_byte);
      hex_word = {sr_q[PHASE_W-5:0], hv[3:0]};
      in_cmd   = (state_q == ST_HEX) || (state_q == ST_CHSEL);
      tmo_exp  = in_cmd && !bus.rx_dv && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      tmo_d    = (bus.rx_dv || !in_cmd) ? '0 : tmo_q + 1'b1;

      case (state_q)
         ST_IDLE: if (bus.rx_dv) begin
            done  = 1'b1;
            ack_d = ACK_OK;
            case (bus.rx_byte)
               "a": begin phase_d[ach_q] = PRESET_A; upd_d = 1'b1; end
               "b": begin phase_d[ach_q] = PRESET_B; upd_d = 1'b1; end
               "m": begin step = STEP_COARSE; step_up = 1'b1; end
               "n": begin step = STEP_COARSE; step_dn = 1'b1; end
               "r": begin step = STEP_MID;    step_up = 1'b1; end
               "q": begin step = STEP_MID;    step_dn = 1'b1; end
               "p": begin step = STEP_FINE;   step_up = 1'b1; end
               "o": begin step = STEP_FINE;   step_dn = 1'b1; end
               "x": begin done = 1'b0; go_hex = 1'b1; sr_d = '0; cnt_d = '0; end
               "c": begin done = 1'b0; go_chsel = 1'b1; end
               default: begin
                  if (bus.rx_byte >= "0" && bus.rx_byte <= "9") begin
                     gain_d = (int'(bus.rx_byte[3:0]) > GAIN_MAX) ? GAIN_W'(GAIN_MAX)
                                                                  : GAIN_W'(bus.rx_byte[3:0]);
                     upd_d  = 1'b1;
                  end else begin
                     ack_d = ACK_BAD;
                  end
               end
            endcase
            // Steps are evaluated one bit wider so both overflow and underflow are visible.
            if (step_up) begin
               sum   = {1'b0, cur} + {1'b0, step};
               upd_d = 1'b1;
               if (sum > {1'b0, MAX_INC}) begin
                  phase_d[ach_q] = MAX_INC; ack_d = ACK_CLAMP;
               end else begin
                  phase_d[ach_q] = sum[PHASE_W-1:0];
               end
            end else if (step_dn) begin
               sum   = {1'b0, cur} - {1'b0, step};
               upd_d = 1'b1;
               if (sum[PHASE_W]) begin
                  phase_d[ach_q] = '0; ack_d = ACK_CLAMP;
               end else begin
                  phase_d[ach_q] = sum[PHASE_W-1:0];
               end
            end
         end
         ST_HEX: begin
            if (bus.rx_dv) begin
               if (hv[4]) begin
                  sr_d  = hex_word;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(DIGITS - 1)) begin
                     done = 1'b1;
                     if (hex_word <= MAX_INC) begin
                        phase_d[ach_q] = hex_word; upd_d = 1'b1; ack_d = ACK_OK;
                     end else begin
                        ack_d = ACK_CLAMP;
                     end
                  end
               end else begin
                  done = 1'b1; ack_d = ACK_BAD;
               end
            end else if (tmo_exp) begin
               done = 1'b1; ack_d = ACK_BAD;
            end
         end
         ST_CHSEL: begin
            if (bus.rx_dv) begin
               done = 1'b1;
               if (bus.rx_byte >= "0" && int'(bus.rx_byte) < 48 + NUM_CH) begin
                  ach_d = CH_W'(bus.rx_byte - 8'h30); ack_d = ACK_OK;
               end else begin
                  ack_d = ACK_BAD;
               end
            end else if (tmo_exp) begin
               done = 1'b1; ack_d = ACK_BAD;
            end
         end
`ifdef SDR_TUNE_CTRL_ACK_EN
         ST_ACK: if (bus.rx_dv) ovr_d = 1'b1;
`endif
         default: ;
      endcase
   end

   // Acknowledge handshake outputs: strobe as soon as the transmitter is free.
   always_comb begin
`ifdef SDR_TUNE_CTRL_ACK_EN
      bus.tx_dv   = (state_q == ST_ACK) && !bus.tx_active;
      bus.tx_byte = ack_q;
`else
      bus.tx_dv   = 1'b0;
      bus.tx_byte = 8'd0;
`endif
   end

`ifndef SDR_TUNE_CTRL_ACK_EN
   logic unused_ack;
   assign unused_ack = ^{ack_q, bus.tx_active};
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_out
      assign phase_inc[k*PHASE_W +: PHASE_W] = phase_q[k];
   end
   assign cic_gain   = gain_q;
   assign active_ch  = ach_q;
   assign update     = upd_q;
   assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Self-checking bench for sdr_tune_ctrl: directed test-plan steps plus random command stream.
// Expected values come from a byte-level command model kept in this file.
// Timeout is shortened so the idle-abort scenarios fit in a short run.
module tb_sdr_tune_ctrl;
   localparam int NUM_CH = 2;
   localparam int TMO    = 40;
   localparam logic [63:0] PA   = 64'h04CF41F212D77318;
   localparam logic [63:0] PB   = 64'h01AA60F8B8911654;
   localparam logic [63:0] SC   = 64'h00071B375868D170;
   localparam logic [63:0] SM   = 64'h0000CA22980BA57E;
   localparam logic [63:0] SF   = 64'h00001436A8CDF6F3;
   localparam logic [63:0] MAXI = 64'h2000000000000000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sdr_tune_ctrl_if bus();
   logic [NUM_CH*64-1:0] phase_inc;
   logic [7:0]           cic_gain;
   logic [0:0]           active_ch;
   logic                 update, rx_overrun;

   sdr_tune_ctrl #(.PHASE_W(64), .NUM_CH(NUM_CH), .GAIN_W(8), .GAIN_MAX(3),
                   .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus), .phase_inc(phase_inc), .cic_gain(cic_gain),
      .active_ch(active_ch), .update(update), .rx_overrun(rx_overrun));

   int vectors = 0;
   int errs    = 0;

   // Reference model state
   logic [63:0] m_ph [NUM_CH];
   int          m_gain, m_ach, m_mode;   // mode: 0 idle, 1 hex, 2 channel select
   logic [63:0] m_hex;
   int          m_cnt;
   bit          m_ovr;

   // Transmit monitor
   int         tx_cnt  = 0;
   logic [7:0] tx_last = 8'd0;
   always @(negedge clk) begin
      #1;
      if (bus.tx_dv === 1'b1) begin tx_cnt++; tx_last = bus.tx_byte; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_model(input logic [63:0] st, input bit up, inout logic [7:0] ack);
      logic [63:0] c;
      c = m_ph[m_ach];
      if (up) begin
         if (st > MAXI - c) begin c = MAXI; ack = "!"; end else c = c + st;
      end else begin
         if (st > c) begin c = 0; ack = "!"; end else c = c - st;
      end
      m_ph[m_ach] = c;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit upd, output bit done,
                             output logic [7:0] ack);
      int v;
      upd = 0; done = 1; ack = "K";
      if (m_mode == 0) begin
         if (b >= "0" && b <= "9") begin
            v = int'(b) - 48; m_gain = (v > 3) ? 3 : v; upd = 1;
         end else begin
            case (b)
               "a": begin m_ph[m_ach] = PA; upd = 1; end
               "b": begin m_ph[m_ach] = PB; upd = 1; end
               "m": begin step_model(SC, 1, ack); upd = 1; end
               "n": begin step_model(SC, 0, ack); upd = 1; end
               "r": begin step_model(SM, 1, ack); upd = 1; end
               "q": begin step_model(SM, 0, ack); upd = 1; end
               "p": begin step_model(SF, 1, ack); upd = 1; end
               "o": begin step_model(SF, 0, ack); upd = 1; end
               "x": begin m_mode = 1; m_hex = 0; m_cnt = 0; done = 0; end
               "c": begin m_mode = 2; done = 0; end
               default: ack = "?";
            endcase
         end
      end else if (m_mode == 1) begin
         v = -1;
         if (b >= "0" && b <= "9") v = int'(b) - 48;
         if (b >= "a" && b <= "f") v = int'(b) - 87;
         if (b >= "A" && b <= "F") v = int'(b) - 55;
         if (v < 0) begin
            m_mode = 0; ack = "?";
         end else begin
            m_hex = m_hex * 16 + 64'(v);
            m_cnt++;
            if (m_cnt == 16) begin
               m_mode = 0;
               if (m_hex <= MAXI) begin m_ph[m_ach] = m_hex; upd = 1; end
               else ack = "!";
            end else begin
               done = 0;
            end
         end
      end else begin
         m_mode = 0;
         if (int'(b) >= 48 && int'(b) < 48 + NUM_CH) m_ach = int'(b) - 48;
         else ack = "?";
      end
   endtask

   // Returns 1 when the idle gap aborts a pending multi-byte command.
   function automatic bit model_idle(input int gap);
      if (m_mode != 0 && gap >= TMO) begin m_mode = 0; return 1'b1; end
      return 1'b0;
   endfunction

   task automatic check_state(input string tag, input bit upd);
      for (int k = 0; k < NUM_CH; k++)
         chk({tag, "_phase"}, phase_inc[k*64 +: 64], m_ph[k]);
      chk({tag, "_gain"}, 64'(cic_gain), 64'(m_gain));
      chk({tag, "_ach"}, 64'(active_ch), 64'(m_ach));
      chk({tag, "_update"}, 64'(update), 64'(upd));
      chk({tag, "_overrun"}, 64'(rx_overrun), 64'(m_ovr));
   endtask

   task automatic send_chk(input logic [7:0] b);
      bit upd, done;
      logic [7:0] ack;
      model_byte(b, upd, done, ack);
      @(negedge clk);
      bus.rx_dv = 1'b1; bus.rx_byte = b;
      @(negedge clk);
      bus.rx_dv = 1'b0;
      check_state("cmd", upd);
`ifdef SDR_TUNE_CTRL_ACK_EN
      chk("tx_dv", 64'(bus.tx_dv), 64'(done));
      if (done) chk("tx_byte", 64'(bus.tx_byte), 64'(ack));
`else
      chk("tx_dv_off", 64'(bus.tx_dv), 64'd0);
      chk("tx_byte_off", 64'(bus.tx_byte), 64'd0);
`endif
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_chk(s[i]);
   endtask

   initial begin
      string cmds, hexs;
      int    tc0, r;
      bit    upd, done, ab;
      logic [7:0] ack, c;

      for (int k = 0; k < NUM_CH; k++) m_ph[k] = 0;
      m_gain = 0; m_ach = 0; m_mode = 0; m_hex = 0; m_cnt = 0; m_ovr = 0;
      rst = 1'b1; bus.rx_dv = 1'b0; bus.rx_byte = 8'd0; bus.tx_active = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_state("reset", 0);
      chk("reset_tx_dv", 64'(bus.tx_dv), 64'd0);
      chk("reset_tx_byte", 64'(bus.tx_byte), 64'd0);

      // Directed test-plan steps
      send_chk("a");
      chk("preset_a_const", phase_inc[63:0], PA);
      send_str("c1bm");
      chk("ch0_kept", phase_inc[63:0], PA);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_ph[k] = 0;
      m_gain = 0; m_ach = 0; m_mode = 0;
      send_chk("o");
      send_chk("7");
      chk("gain_clamp_const", 64'(cic_gain), 64'd3);
      send_str("x0000000000100000");
      chk("hex_load_const", phase_inc[63:0], 64'h100000);
      send_str("xFFFFFFFFFFFFFFFF");
      send_str("x1g");
      send_str("Zm");

      // Timeout: gap longer than the limit aborts the hex entry
      send_str("x1");
      tc0 = tx_cnt;
      repeat (TMO + 5) @(negedge clk);
      ab = model_idle(TMO + 6);
      chk("tmo_abort_model", 64'(ab), 64'd1);
      check_state("tmo", 0);
`ifdef SDR_TUNE_CTRL_ACK_EN
      chk("tmo_tx_cnt", 64'(tx_cnt - tc0), 64'd1);
      chk("tmo_tx_byte", 64'(tx_last), 64'("?"));
`else
      chk("tmo_tx_cnt", 64'(tx_cnt), 64'd0);
`endif
      send_chk("b");
      // A shorter gap keeps the hex entry alive
      send_str("x00000000");
      repeat (TMO - 10) @(negedge clk);
      ab = model_idle(TMO - 9);
      send_str("00ABCDEF");

      // Overrun: hold the transmitter busy and send two bytes back-to-back
      @(negedge clk);
      bus.tx_active = 1'b1;
      tc0 = tx_cnt;
      model_byte("a", upd, done, ack);
`ifdef SDR_TUNE_CTRL_ACK_EN
      m_ovr = 1; upd = 0;
`else
      model_byte("b", upd, done, ack);
`endif
      bus.rx_dv = 1'b1; bus.rx_byte = "a";
      @(negedge clk);
      bus.rx_byte = "b";
      @(negedge clk);
      bus.rx_dv = 1'b0;
      check_state("ovr", upd);
      repeat (3) @(negedge clk);
      chk("ovr_held_cnt", 64'(tx_cnt - tc0), 64'd0);
      bus.tx_active = 1'b0;
      #1;
`ifdef SDR_TUNE_CTRL_ACK_EN
      chk("ovr_tx_dv", 64'(bus.tx_dv), 64'd1);
      chk("ovr_tx_byte", 64'(bus.tx_byte), 64'("K"));
`endif
      repeat (4) @(negedge clk);
`ifdef SDR_TUNE_CTRL_ACK_EN
      chk("ovr_one_pulse", 64'(tx_cnt - tc0), 64'd1);
`else
      chk("ovr_no_pulse", 64'(tx_cnt - tc0), 64'd0);
`endif
      check_state("ovr_end", 0);

      // Randomized command stream
      cmds = "abmnrqpo0259xxcc?Z";
      hexs = "0123456789abcdefABCDEF";
      for (int n = 0; n < 150; n++) begin
         c = cmds[$urandom_range(0, cmds.len() - 1)];
         send_chk(c);
         if (c == "x") begin
            for (int d = 0; d < 16; d++) begin
               r = $urandom_range(0, 39);
               if (r == 0) begin send_chk("g"); break; end
               if (d == 0) send_chk((r < 36) ? hexs[$urandom_range(0, 2)] : "F");
               else send_chk(hexs[$urandom_range(0, hexs.len() - 1)]);
            end
         end else if (c == "c") begin
            r = $urandom_range(0, 3);
            send_chk((r == 3) ? 8'("z") : 8'(48 + r));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
